// File: rtl/proc_pkg.sv
// ============================================================================
// Module      : proc_pkg
// Description : Shared opcodes, instruction field positions and sequencer
//               state encoding for the alu_sequencer controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package proc_pkg;

    localparam int OPC_HI = 11;
    localparam int OPC_LO = 8;
    localparam int IMM_HI = 7;
    localparam int IMM_LO = 0;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_AND  = 3'd2;
    localparam logic [2:0] ALU_OR   = 3'd3;
    localparam logic [2:0] ALU_XOR  = 3'd4;
    localparam logic [2:0] ALU_NOT  = 3'd5;
    localparam logic [2:0] ALU_PASS = 3'd6;

    localparam logic [3:0] OP_JMP  = 4'h8;
    localparam logic [3:0] OP_JC   = 4'h9;
    localparam logic [3:0] OP_JZ   = 4'hA;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    // The ALU leaves carry undefined for SUB and PASS, so those keep the flag.
    function automatic logic alu_sets_carry(input logic [2:0] op);
        return (op != ALU_SUB) && (op != ALU_PASS);
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_sequencer.sv
// ============================================================================
// Module      : alu_sequencer
// Description : Fetch/decode/execute controller driving an external 8-bit
//               ALU, with accumulator, carry/zero flags, jumps and HALT.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_sequencer
    import proc_pkg::*;
#(
    parameter int PC_W = 8,
    parameter int IW   = 12
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic [IW-1:0]   imem_rdata,
    input  logic            imem_ack,
    output logic [7:0]      alu_a,
    output logic [7:0]      alu_b,
    output logic [2:0]      alu_op,
    input  logic [7:0]      alu_out,
    input  logic            alu_cy,
    output logic [7:0]      acc,
    output logic            flag_c,
    output logic            flag_z,
    output logic            halted
);

    state_t            r_state, w_state;
    logic [PC_W-1:0]   r_pc,     w_pc;
    logic [IW-1:0]     r_ir,     w_ir;
    logic [7:0]        r_acc,    w_acc;
    logic              r_flag_c, w_flag_c;
    logic              r_flag_z, w_flag_z;
    logic              r_req,    w_req;
    logic [7:0]        r_alu_a,  w_alu_a;
    logic [7:0]        r_alu_b,  w_alu_b;
    logic [2:0]        r_alu_op, w_alu_op;
    logic              r_halted, w_halted;

    logic [3:0]        w_opc;
    logic [7:0]        w_imm;
    logic              w_is_alu;
    logic              w_take;
    logic [PC_W-1:0]   w_pc_inc;

    assign w_opc    = r_ir[OPC_HI:OPC_LO];
    assign w_imm    = r_ir[IMM_HI:IMM_LO];
    assign w_is_alu = (w_opc[3] == 1'b0) && (w_opc[2:0] != 3'd7);
    assign w_take   = (w_opc == OP_JMP)
                   || ((w_opc == OP_JC) && r_flag_c)
                   || ((w_opc == OP_JZ) && r_flag_z);
    assign w_pc_inc = r_pc + PC_W'(1);

    always_comb begin
        w_state  = r_state;
        w_pc     = r_pc;
        w_ir     = r_ir;
        w_acc    = r_acc;
        w_flag_c = r_flag_c;
        w_flag_z = r_flag_z;
        w_req    = 1'b0;
        w_alu_a  = r_alu_a;
        w_alu_b  = r_alu_b;
        w_alu_op = r_alu_op;
        w_halted = r_halted;

        case (r_state)
            ST_IDLE: begin
                if (run) begin
                    w_state = ST_FETCH;
                    w_req   = 1'b1;
                end
            end
            ST_FETCH: begin
                // Request stays asserted until the memory acknowledges.
                if (imem_ack) begin
                    w_ir    = imem_rdata;
                    w_state = ST_DECODE;
                end else begin
                    w_req   = 1'b1;
                end
            end
            ST_DECODE: begin
                if (w_is_alu) begin
                    w_alu_a  = r_acc;
                    w_alu_b  = w_imm;
                    w_alu_op = w_opc[2:0];
                    w_state  = ST_EXEC;
                end else if (w_opc == OP_HALT) begin
                    w_halted = 1'b1;
                    w_state  = ST_HALT;
                end else begin
                    w_pc    = w_take ? PC_W'(w_imm) : w_pc_inc;
                    w_req   = 1'b1;
                    w_state = ST_FETCH;
                end
            end
            ST_EXEC: begin
                w_acc    = alu_out;
                w_flag_z = (alu_out == 8'd0);
                if (alu_sets_carry(r_alu_op)) begin
                    w_flag_c = alu_cy;
                end
                w_pc    = w_pc_inc;
                w_req   = 1'b1;
                w_state = ST_FETCH;
            end
            ST_HALT: begin
                w_state = ST_HALT;
            end
            default: begin
                w_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_pc     <= '0;
            r_ir     <= '0;
            r_acc    <= 8'd0;
            r_flag_c <= 1'b0;
            r_flag_z <= 1'b0;
            r_req    <= 1'b0;
            r_alu_a  <= 8'd0;
            r_alu_b  <= 8'd0;
            r_alu_op <= ALU_PASS;
            r_halted <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_pc     <= w_pc;
            r_ir     <= w_ir;
            r_acc    <= w_acc;
            r_flag_c <= w_flag_c;
            r_flag_z <= w_flag_z;
            r_req    <= w_req;
            r_alu_a  <= w_alu_a;
            r_alu_b  <= w_alu_b;
            r_alu_op <= w_alu_op;
            r_halted <= w_halted;
        end
    end

    assign imem_req  = r_req;
    assign imem_addr = r_pc;
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_op    = r_alu_op;
    assign acc       = r_acc;
    assign flag_c    = r_flag_c;
    assign flag_z    = r_flag_z;
    assign halted    = r_halted;

endmodule

`default_nettype wire

// File: tb/tb_alu_sequencer.sv
// ============================================================================
// Module      : tb_alu_sequencer
// Description : Directed bench for alu_sequencer with an ISA-level model and
//               a behavioural ALU/program memory around the controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n, run;
    logic        imem_req, imem_ack;
    logic [7:0]  imem_addr;
    logic [11:0] imem_rdata;
    logic [7:0]  alu_a, alu_b, alu_out, acc;
    logic [2:0]  alu_op;
    logic        alu_cy, flag_c, flag_z, halted;

    always #5 clk = ~clk;

    alu_sequencer #(.PC_W(8), .IW(12)) dut (
        .clk(clk), .rst_n(rst_n), .run(run),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_ack(imem_ack),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_out(alu_out), .alu_cy(alu_cy),
        .acc(acc), .flag_c(flag_c), .flag_z(flag_z), .halted(halted)
    );

    // Behavioural ALU; undefined carry (SUB/PASS) is driven opposite to the
    // current flag so any wrongful update becomes visible.
    always_comb begin
        alu_out = 8'd0;
        alu_cy  = 1'b0;
        case (alu_op)
            3'd0: {alu_cy, alu_out} = {1'b0, alu_a} + {1'b0, alu_b};
            3'd1: begin alu_out = alu_a - alu_b; alu_cy = ~flag_c; end
            3'd2: alu_out = alu_a & alu_b;
            3'd3: alu_out = alu_a | alu_b;
            3'd4: alu_out = alu_a ^ alu_b;
            3'd5: alu_out = ~alu_a;
            3'd6: begin alu_out = alu_b; alu_cy = ~flag_c; end
            default: alu_out = 8'd0;
        endcase
    end

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    logic [11:0] mem [256];
    int          wait_n    = 0;
    bit          mem_en    = 1'b1;
    bit          force_ack = 1'b0;
    logic [11:0] force_data = 12'h000;

    logic [7:0]  m_pc, m_acc;
    logic        m_c, m_z, m_halt;
    int          fcount [256];
    int          cyc = 0, first_fetch = -1, halt_cyc = -1;
    int          fetch_start = 0, exp_gap = 0, wcnt = 0;
    bit          prev_req = 1'b0, have_gap = 1'b0;
    logic [7:0]  held_addr;

    function automatic bit is_alu(input logic [11:0] ins);
        return (ins[11] == 1'b0) && (ins[10:8] != 3'd7);
    endfunction

    // Architectural effect of one instruction.
    task automatic model_exec(input logic [11:0] ins);
        logic [3:0] op;
        logic [7:0] imm;
        logic [8:0] sum;
        op  = ins[11:8];
        imm = ins[7:0];
        if (is_alu(ins)) begin
            case (op)
                4'h0: begin sum = {1'b0, m_acc} + {1'b0, imm}; m_acc = sum[7:0]; m_c = sum[8]; end
                4'h1: m_acc = m_acc - imm;
                4'h2: begin m_acc = m_acc & imm; m_c = 1'b0; end
                4'h3: begin m_acc = m_acc | imm; m_c = 1'b0; end
                4'h4: begin m_acc = m_acc ^ imm; m_c = 1'b0; end
                4'h5: begin m_acc = ~m_acc;      m_c = 1'b0; end
                default: m_acc = imm;
            endcase
            m_z  = (m_acc == 8'd0);
            m_pc = m_pc + 8'd1;
        end else if (op == 4'h8 || (op == 4'h9 && m_c) || (op == 4'hA && m_z)) begin
            m_pc = imm;
        end else if (op == 4'hF) begin
            m_halt = 1'b1;
        end else begin
            m_pc = m_pc + 8'd1;
        end
    endtask

    // Memory responder and per-cycle comparison against the model.
    initial begin
        imem_ack   = 1'b0;
        imem_rdata = 12'h000;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                m_pc = 8'd0; m_acc = 8'd0; m_c = 1'b0; m_z = 1'b0; m_halt = 1'b0;
                prev_req = 1'b0; wcnt = 0; have_gap = 1'b0;
                first_fetch = -1; halt_cyc = -1;
                for (int i = 0; i < 256; i++) fcount[i] = 0;
                imem_ack = 1'b0;
            end else begin
                if (halted) begin
                    if (halt_cyc < 0) halt_cyc = cyc;
                    chk("halt_model", int'(m_halt), 1);
                    chk("halt_req", int'(imem_req), 0);
                    chk("halt_acc", int'(acc), int'(m_acc));
                    chk("halt_pc", int'(imem_addr), int'(m_pc));
                    chk("halt_c", int'(flag_c), int'(m_c));
                    chk("halt_z", int'(flag_z), int'(m_z));
                end
                if (imem_req) begin
                    if (!prev_req) begin
                        chk("fetch_addr", int'(imem_addr), int'(m_pc));
                        chk("fetch_acc", int'(acc), int'(m_acc));
                        chk("fetch_c", int'(flag_c), int'(m_c));
                        chk("fetch_z", int'(flag_z), int'(m_z));
                        if (first_fetch < 0) first_fetch = cyc;
                        if (have_gap) chk("fetch_gap", cyc - fetch_start, exp_gap);
                        fetch_start = cyc;
                        held_addr   = imem_addr;
                    end else begin
                        chk("addr_hold", int'(imem_addr), int'(held_addr));
                    end
                end
                if (force_ack) begin
                    imem_ack   = 1'b1;
                    imem_rdata = force_data;
                end else if (imem_req && mem_en) begin
                    if (wcnt == wait_n) begin
                        imem_ack   = 1'b1;
                        imem_rdata = mem[imem_addr];
                        fcount[imem_addr]++;
                        exp_gap  = wait_n + 2 + (is_alu(mem[imem_addr]) ? 1 : 0);
                        have_gap = 1'b1;
                        model_exec(mem[imem_addr]);
                        wcnt = 0;
                    end else begin
                        imem_ack = 1'b0;
                        wcnt++;
                    end
                end else begin
                    imem_ack = 1'b0;
                end
                prev_req = imem_req;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        tick(); rst_n = 1'b0;
        tick(); rst_n = 1'b1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 12'hF00;
    endtask

    task automatic start();
        tick(); run = 1'b1;
        tick(); run = 1'b0;
    endtask

    task automatic wait_halt();
        for (int i = 0; i < 300 && !halted; i++) tick();
        if (!halted) chk("halt_timeout", 0, 1);
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        run   = 1'b0;
        clear_mem();
        repeat (3) tick();
        rst_n = 1'b1;

        chk("rst_req", int'(imem_req), 0);
        chk("rst_addr", int'(imem_addr), 0);
        chk("rst_acc", int'(acc), 0);
        chk("rst_op", int'(alu_op), 6);
        chk("rst_a", int'(alu_a), 0);
        chk("rst_b", int'(alu_b), 0);
        chk("rst_flags", int'({flag_c, flag_z}), 0);
        chk("rst_halted", int'(halted), 0);
        tick();
        chk("idle_req", int'(imem_req), 0);

        // Basic program, zero-wait memory
        mem[0] = 12'h605; mem[1] = 12'h003; mem[2] = 12'hF00;
        start();
        wait_halt();
        chk("t1_acc", int'(acc), 8'h08);
        chk("t1_flags", int'({flag_c, flag_z}), 0);
        chk("t1_latency", halt_cyc - first_fetch, 8);
        chk("t1_req", int'(imem_req), 0);

        // HALT is sticky against run and stray acks
        run = 1'b1; force_data = 12'h605;
        for (int i = 0; i < 4; i++) begin
            force_ack = (i % 2 == 0);
            tick();
            chk("sticky_halted", int'(halted), 1);
            chk("sticky_acc", int'(acc), 8'h08);
        end
        force_ack = 1'b0; run = 1'b0;
        do_reset();
        chk("unhalt", int'(halted), 0);
        chk("unhalt_req", int'(imem_req), 0);
        tick();
        chk("unhalt_idle", int'(imem_req), 0);

        // Carry and taken JC skipping address 3
        clear_mem();
        mem[0] = 12'h6FF; mem[1] = 12'h001; mem[2] = 12'h905;
        mem[3] = 12'h0AA; mem[4] = 12'h0BB; mem[5] = 12'hF00;
        start();
        wait_halt();
        chk("t2_acc", int'(acc), 8'h00);
        chk("t2_c", int'(flag_c), 1);
        chk("t2_z", int'(flag_z), 1);
        chk("t2_skip3", fcount[3], 0);
        chk("t2_hit5", fcount[5], 1);
        do_reset();

        // SUB and PASS keep the carry
        clear_mem();
        mem[0] = 12'h6FF; mem[1] = 12'h004; mem[2] = 12'h101;
        mem[3] = 12'h600; mem[4] = 12'hF00;
        start();
        wait_halt();
        chk("t3_acc", int'(acc), 8'h00);
        chk("t3_c", int'(flag_c), 1);
        chk("t3_z", int'(flag_z), 1);
        do_reset();

        // Logic ops clear carry, JZ not taken, NOPs
        clear_mem();
        mem[0] = 12'h6F0; mem[1] = 12'h020; mem[2] = 12'h2FC; mem[3] = 12'h30F;
        mem[4] = 12'h4FF; mem[5] = 12'h500; mem[6] = 12'hA07; mem[7] = 12'h700;
        mem[8] = 12'hC00; mem[9] = 12'hF00;
        start();
        wait_halt();
        chk("t4_acc", int'(acc), 8'h1F);
        chk("t4_flags", int'({flag_c, flag_z}), 0);
        chk("t4_nop7", fcount[7], 1);
        do_reset();

        // Three wait states per fetch
        clear_mem();
        wait_n = 3;
        mem[0] = 12'h605; mem[1] = 12'h003; mem[2] = 12'hF00;
        start();
        wait_halt();
        chk("t5_acc", int'(acc), 8'h08);
        chk("t5_latency", halt_cyc - first_fetch, 17);
        do_reset();
        wait_n = 0;

        // PC wrap, then reset while a fetch is pending
        clear_mem();
        mem[0] = 12'h655; mem[1] = 12'h8FF; mem[255] = 12'hB00;
        start();
        for (int i = 0; i < 100 && fcount[255] == 0; i++) tick();
        chk("wrap_reached", fcount[255], 1);
        mem_en = 1'b0;
        for (int i = 0; i < 20 && !imem_req; i++) tick();
        chk("wrap_req", int'(imem_req), 1);
        chk("wrap_addr", int'(imem_addr), 0);
        chk("wrap_acc", int'(acc), 8'h55);
        rst_n = 1'b0;
        tick();
        chk("midrst_req", int'(imem_req), 0);
        chk("midrst_acc", int'(acc), 0);
        chk("midrst_addr", int'(imem_addr), 0);
        rst_n = 1'b1; force_ack = 1'b1; force_data = 12'h605;
        tick();
        force_ack = 1'b0;
        tick();
        chk("late_ack_req", int'(imem_req), 0);
        chk("late_ack_acc", int'(acc), 0);
        chk("late_ack_alu_b", int'(alu_b), 0);
        chk("late_ack_addr", int'(imem_addr), 0);
        mem_en = 1'b1;

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Fetch/decode/execute controller for the 8-bit `alu` datapath (ops 0–6: ADD, SUB, AND, OR, XOR, NOT, PASS-B).
- Fetches 12-bit instructions from an external program memory over a req/ack handshake.
- Drives the ALU operands and opcode, and writes results back to an 8-bit accumulator.
- Maintains carry/zero flags and a program counter, resolves jumps, and stops on HALT.

Parameters:
- PC_W, 8, program counter / instruction address width.
- IW, 12, instruction width: [11:8] opcode, [7:0] immediate or jump target.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- run  in  1  start request; sampled only in IDLE.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  PC_W  fetch address (= pc).
- imem_rdata  in  IW  instruction word; valid when imem_ack=1.
- imem_ack  in  1  fetch acknowledge.
- alu_a  out  8  ALU operand a (= accumulator).
- alu_b  out  8  ALU operand b (= immediate).
- alu_op  out  3  ALU opcode.
- alu_out  in  8  ALU result.
- alu_cy  in  1  ALU carry.
- acc  out  8  accumulator.
- flag_c  out  1  carry flag.
- flag_z  out  1  zero flag.
- halted  out  1  high in HALT state.

Behaviour:
- One clock domain. Reset is synchronous, active-low: all state updates only on the rising clk edge with rst_n=0.
- Reset values: state=IDLE, pc=0, ir=0, acc=0, flag_c=0, flag_z=0, imem_req=0, alu_a=0, alu_b=0, alu_op=3'b110, halted=0. All outputs are registered.
- Reset mid-operation (any state, including a pending fetch) returns to IDLE in the same edge. A late imem_ack is ignored.
- Opcodes:
  - 0x0–0x6: ALU ops, alu_op=opcode[2:0], b=imm.
  - 0x8: JMP imm.
  - 0x9: JC (jump if flag_c).
  - 0xA: JZ (jump if flag_z).
  - 0xF: HALT.
  - 0x7, 0xB–0xE: NOP.
- States:
  - IDLE: imem_req=0. run=1 → FETCH.
  - FETCH: imem_req=1, imem_addr=pc.
    - imem_ack=1 in the same cycle → latch ir=imem_rdata, drop imem_req next cycle, go to DECODE.
    - Otherwise hold the request indefinitely.
    - Ack may arrive in the first FETCH cycle (zero-wait memory).
  - DECODE:
    - ALU op: load alu_a=acc, alu_b=ir[7:0], alu_op=ir[10:8] → EXEC.
    - Taken jump: pc=ir[7:0] → FETCH.
    - Not-taken jump or NOP: pc=pc+1 → FETCH.
    - HALT → HALT (pc unchanged).
  - EXEC (one cycle; ALU is combinational and inputs are stable all cycle):
    - acc=alu_out, flag_z=(alu_out==0), pc=pc+1 → FETCH.
    - flag_c=alu_cy for ops 0, 2, 3, 4, 5.
    - flag_c unchanged for ops 1 (SUB) and 6 (PASS), because the ALU does not define CY for them.
  - HALT: halted=1, imem_req=0. Exit only via reset; run is ignored.
- Latency, with a zero-wait ack: ALU instruction 3 cycles; jump/NOP 2 cycles; each extra memory wait cycle adds 1.
- Arithmetic/width rules:
  - pc increments modulo 2^PC_W (0xFF+1 → 0x00, no flag).
  - Flags only change in EXEC.
  - imem_ack outside FETCH is ignored.

Decomposition:
- Shared package `proc_pkg` holds:
  - ALU opcode constants (ALU_ADD … ALU_PASS).
  - Instruction opcode constants (OP_JMP, OP_JC, OP_JZ, OP_HALT).
  - State encoding for IDLE/FETCH/DECODE/EXEC/HALT.
  - Field positions for IW.
- No sub-module needed. The `alu` instance lives one level up, wired to the alu_* ports. The top-level bench instantiates both.

Test Plan:
- Reset then run=1 with zero-wait memory, program {0x605, 0x003, 0xF00}: acc=0x05 then 0x08; flag_c=0; flag_z=0; halted=1 after 8 cycles from the first FETCH; imem_req=0 in HALT.
- Carry and JC, program {0x6FF, 0x001, 0x905, …, [5]=0xF00}: acc=0x00, flag_c=1, flag_z=1; JC taken to 0x05; the instruction at 0x03 is never fetched.
- SUB and PASS leave the carry alone: after ADD sets flag_c=1, execute 0x101 with acc=0x03 → acc=0x02, flag_c stays 1. Then 0x600 → acc=0x00, flag_z=1, flag_c still 1.
- Memory wait states: ack delayed 3 cycles on every fetch → imem_req held high and imem_addr stable until ack; ALU instruction takes 6 cycles; results identical to the zero-wait run.
- PC wrap: JMP 0xFF to a NOP at 0xFF → next imem_addr=0x00. Reset asserted while a FETCH is pending → next cycle state=IDLE, imem_req=0, acc=0, pc=0; an ack arriving then causes no change.
- HALT stickiness: in HALT, toggle run and pulse imem_ack → halted stays 1 and no register changes. Reset → halted=0, back in IDLE.
